// File: rtl/reg_bank8x16.sv
// reg_bank8x16: eight-entry register bank with per-entry valid flags and a
// free-running scan pointer that drives a downstream 8-way word multiplexer.
// Entries are exposed flat on `words`; `sel` walks them when scan_en is high.
module reg_bank8x16 #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [WIDTH-1:0]       in,
   input  logic                   load,
   input  logic [2:0]             wr_addr,
   input  logic                   clr,
   input  logic                   scan_en,
   output logic [DEPTH*WIDTH-1:0] words,
   output logic [2:0]             sel,
   output logic [DEPTH-1:0]       valid,
   output logic                   sel_valid,
   output logic                   scan_wrap
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [2:0]       r_sel;
   logic             r_wrap;

   // Storage and valid flags: clear beats load, only the addressed entry changes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_valid <= '0;
      end else if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_valid <= '0;
      end else if (load) begin
         r_mem[wr_addr]   <= in;
         r_valid[wr_addr] <= 1'b1;
      end
   end

   // Scan pointer and wrap pulse: the pulse is high for the cycle after 7 -> 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel  <= 3'd0;
         r_wrap <= 1'b0;
      end else if (clr) begin
         r_sel  <= 3'd0;
         r_wrap <= 1'b0;
      end else begin
         if (scan_en) begin
            r_sel <= r_sel + 3'd1;
         end
         r_wrap <= scan_en && (r_sel == 3'd7);
      end
   end

   // Flatten the entries so entry i sits at bits [WIDTH*i +: WIDTH].
   always_comb begin
      words = '0;
      for (int i = 0; i < DEPTH; i++) begin
         words[i*WIDTH +: WIDTH] = r_mem[i];
      end
   end

   assign sel       = r_sel;
   assign valid     = r_valid;
   assign scan_wrap = r_wrap;
   assign sel_valid = r_valid[r_sel];

endmodule

// File: tb/tb_reg_bank8x16.sv
// Directed testbench for reg_bank8x16.
module tb_reg_bank8x16;

   logic         clk;
   logic         rst_n;
   logic [15:0]  d_in;
   logic         load;
   logic [2:0]   wr_addr;
   logic         clr;
   logic         scan_en;
   logic [127:0] words;
   logic [2:0]   sel;
   logic [7:0]   valid;
   logic         sel_valid;
   logic         scan_wrap;

   int checks;
   int failures;
   int wraps;

   logic [127:0] exp_words;

   reg_bank8x16 #(.WIDTH(16), .DEPTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (d_in),
      .load      (load),
      .wr_addr   (wr_addr),
      .clr       (clr),
      .scan_en   (scan_en),
      .words     (words),
      .sel       (sel),
      .valid     (valid),
      .sel_valid (sel_valid),
      .scan_wrap (scan_wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One rising edge, then land on the falling edge for sampling/driving.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [15:0] ent(input int i);
      return words[i*16 +: 16];
   endfunction

   initial begin
      checks   = 0;
      failures = 0;
      wraps    = 0;
      rst_n    = 1'b0;
      d_in     = 16'h0;
      load     = 1'b0;
      wr_addr  = 3'd0;
      clr      = 1'b0;
      scan_en  = 1'b0;

      // Reset state
      #2;
      chk("rst_words", words, 128'h0);
      chk("rst_valid", {120'h0, valid}, 128'h0);
      chk("rst_sel", {125'h0, sel}, 128'h0);
      chk("rst_wrap", {127'h0, scan_wrap}, 128'h0);
      chk("rst_selv", {127'h0, sel_valid}, 128'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fill test
      load = 1'b1;
      wr_addr = 3'd0; d_in = 16'haabb; step();
      chk("fill_lat_e0", {112'h0, ent(0)}, {112'h0, 16'haabb});
      chk("fill_lat_v", {120'h0, valid}, {120'h0, 8'h01});
      wr_addr = 3'd1; d_in = 16'hccdd; step();
      wr_addr = 3'd2; d_in = 16'h1122; step();
      wr_addr = 3'd3; d_in = 16'h3344; step();
      wr_addr = 3'd4; d_in = 16'h5566; step();
      wr_addr = 3'd5; d_in = 16'h7788; step();
      wr_addr = 3'd6; d_in = 16'h9900; step();
      wr_addr = 3'd7; d_in = 16'h0000; step();
      load = 1'b0;
      exp_words = 128'h0000_9900_7788_5566_3344_1122_ccdd_aabb;
      chk("fill_words", words, exp_words);
      chk("fill_valid", {120'h0, valid}, {120'h0, 8'hFF});
      chk("fill_sel", {125'h0, sel}, 128'h0);

      // Back-to-back writes to one address; neighbours untouched
      load = 1'b1; wr_addr = 3'd1;
      d_in = 16'h1111; step();
      chk("b2b_first", {112'h0, ent(1)}, {112'h0, 16'h1111});
      chk("b2b_e0", {112'h0, ent(0)}, {112'h0, 16'haabb});
      chk("b2b_e2", {112'h0, ent(2)}, {112'h0, 16'h1122});
      d_in = 16'h2222; step();
      d_in = 16'hccdd; step();
      load = 1'b0;
      chk("b2b_words", words, exp_words);

      // Hold test
      d_in = 16'hdead; wr_addr = 3'd5;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("hold_words", words, exp_words);
         chk("hold_valid", {120'h0, valid}, {120'h0, 8'hFF});
         chk("hold_sel", {125'h0, sel}, 128'h0);
         chk("hold_wrap", {127'h0, scan_wrap}, 128'h0);
      end

      // Scan/wrap test: 17 edges from sel=0
      scan_en = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         step();
         chk("scan_sel", {125'h0, sel}, 128'(k % 8));
         chk("scan_wrap", {127'h0, scan_wrap}, 128'((k % 8) == 0));
         chk("scan_selv", {127'h0, sel_valid}, 128'h1);
         if (scan_wrap) wraps++;
      end
      scan_en = 1'b0;
      chk("scan_wrap_cnt", 128'(wraps), 128'd2);
      step();
      chk("scan_hold_sel", {125'h0, sel}, 128'd1);
      chk("scan_hold_wrap", {127'h0, scan_wrap}, 128'h0);

      // Clear test: clr beats load and scan_en
      clr = 1'b1; load = 1'b1; wr_addr = 3'd3; d_in = 16'hffff; scan_en = 1'b1;
      step();
      clr = 1'b0; load = 1'b0; scan_en = 1'b0;
      chk("clr_words", words, 128'h0);
      chk("clr_valid", {120'h0, valid}, 128'h0);
      chk("clr_sel", {125'h0, sel}, 128'h0);
      chk("clr_wrap", {127'h0, scan_wrap}, 128'h0);
      step();
      chk("clr_e3", {112'h0, ent(3)}, 128'h0);

      // Concurrent write and scan at sel=4
      scan_en = 1'b1;
      for (int k = 0; k < 4; k++) step();
      chk("conc_sel4", {125'h0, sel}, 128'd4);
      chk("conc_selv0", {127'h0, sel_valid}, 128'h0);
      load = 1'b1; wr_addr = 3'd4; d_in = 16'hbeef;
      step();
      load = 1'b0;
      chk("conc_sel5", {125'h0, sel}, 128'd5);
      chk("conc_e4", {112'h0, ent(4)}, {112'h0, 16'hbeef});
      chk("conc_valid", {120'h0, valid}, {120'h0, 8'h10});
      chk("conc_selv5", {127'h0, sel_valid}, 128'h0);
      for (int k = 0; k < 7; k++) step();
      scan_en = 1'b0;
      chk("conc_back4", {125'h0, sel}, 128'd4);
      chk("conc_selv1", {127'h0, sel_valid}, 128'h1);

      // Async reset test: reach sel=5, valid=0F
      clr = 1'b1; step(); clr = 1'b0;
      scan_en = 1'b1; load = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wr_addr = 3'(k); d_in = 16'h0100 + 16'(k);
         step();
      end
      load = 1'b0;
      step();
      scan_en = 1'b0;
      chk("ar_pre_sel", {125'h0, sel}, 128'd5);
      chk("ar_pre_valid", {120'h0, valid}, {120'h0, 8'h0F});
      load = 1'b1; wr_addr = 3'd6; d_in = 16'hdead;
      #2 rst_n = 1'b0;
      #1;
      chk("ar_words", words, 128'h0);
      chk("ar_valid", {120'h0, valid}, 128'h0);
      chk("ar_sel", {125'h0, sel}, 128'h0);
      chk("ar_wrap", {127'h0, scan_wrap}, 128'h0);
      chk("ar_selv", {127'h0, sel_valid}, 128'h0);
      step();
      chk("ar_abort", words, 128'h0);
      rst_n = 1'b1;
      wr_addr = 3'd2; d_in = 16'h1234;
      step();
      load = 1'b0;
      chk("ar_post_words", words, {80'h0, 16'h1234, 32'h0});
      chk("ar_post_valid", {120'h0, valid}, {120'h0, 8'h04});
      chk("ar_post_sel", {125'h0, sel}, 128'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/reg_bank8x16.md
REG_BANK8X16 -- requirements
Module: reg_bank8x16

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the bit width of each stored word.
REQ-002 SHALL have parameter DEPTH, default 8, the entry count; only 8 is supported, with 3-bit addressing.
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in, input, WIDTH, the write data.
REQ-006 SHALL have port load, input, 1, the write enable.
REQ-007 SHALL have port wr_addr, input, 3, the write entry index.
REQ-008 SHALL have port clr, input, 1, the synchronous clear of all entries and the scan pointer.
REQ-009 SHALL have port scan_en, input, 1, which advances the scan pointer.
REQ-010 SHALL have port words, output, 8*WIDTH; entry i occupies bits [WIDTH*i+WIDTH-1 : WIDTH*i]; feeds the downstream Mux8Way16 data inputs directly.
REQ-011 SHALL have port sel, output, 3, the scan pointer; drives the downstream Mux8Way16 select.
REQ-012 SHALL have port valid, output, 8, one bit per entry: set when the entry has been written since the last reset or clear.
REQ-013 SHALL have port sel_valid, output, 1, equal to valid[sel], combinational from registered state.
REQ-014 SHALL have port scan_wrap, output, 1, a one-cycle pulse marking completion of a full scan.

Function
REQ-015 With load=1 and clr=0, the rising edge SHALL write in into entry wr_addr and set valid[wr_addr]; the new value SHALL appear on words after the edge (1-cycle write latency).
REQ-016 With load=0, all entries SHALL hold their values.
REQ-017 A write SHALL affect only the addressed entry; the other 7 entries and valid bits SHALL be unchanged.
REQ-018 Back-to-back writes to the same address SHALL leave the last written value.
REQ-019 clr=1 at an edge SHALL zero all entries, all valid bits, sel and scan_wrap.
REQ-020 clr SHALL take priority over load and scan_en in the same cycle; no write SHALL occur.
REQ-021 With scan_en=1 and clr=0, sel SHALL increment by 1 each edge, modulo 8 (7 -> 0).
REQ-022 With scan_en=0, sel SHALL hold its value.
REQ-023 scan_wrap SHALL be registered and SHALL be 1 exactly for the cycle after an edge that moved sel from 7 to 0; otherwise it SHALL be 0.
REQ-024 Writes and scanning SHALL be independent.
REQ-025 A write to entry sel at an edge SHALL be visible on words in the next cycle, regardless of sel moving at the same edge.
REQ-026 Continuous scan_en=1 SHALL give a period-8 sel sequence 0..7 and a scan_wrap pulse every 8 cycles.

Reset
REQ-027 While rst_n=0, all entries SHALL be 0 immediately and independent of clk, and valid=8'h00, sel=0, scan_wrap=0, sel_valid=0.
REQ-028 An rst_n assertion mid-operation SHALL abort any pending write.
REQ-029 The first edge after rst_n deasserts SHALL operate normally, honouring load and scan_en.
REQ-030 No output SHALL be X after reset.

Verification
REQ-031 Write the fill test: write aabb, ccdd, 1122, 3344, 5566, 7788, 9900, 0000 to addresses 0..7 -> words equals {0000,9900,7788,5566,3344,1122,ccdd,aabb} (entry 7 down to 0), valid=8'hFF.
REQ-032 Scan/wrap test: scan_en=1 for 17 cycles from sel=0 -> sel steps 1..7,0,1..7,0,1, with scan_wrap high on exactly 2 cycles, each when sel becomes 0.
REQ-033 Clear test: clr=1 with load=1, wr_addr=3, in=ffff -> words all 0, valid=0, sel=0, and entry 3 stays 0.
REQ-034 Async reset test: drop rst_n between edges while sel=5 and valid=8'h0F -> outputs zero before the next edge; after release plus one edge with load=1, wr_addr=2, in=1234, only entry 2=1234 and valid=8'h04.
REQ-035 Concurrent test: sel=4, scan_en=1, load=1, wr_addr=4, in=beef -> the next cycle has sel=5 and entry 4=beef; when sel returns to 4, sel_valid=1.
REQ-036 Hold test: load=0, scan_en=0 for 10 cycles -> words, valid and sel unchanged, and scan_wrap stays 0.
